// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard front end: deframer states,
// frame geometry and the odd-parity helper.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam int FRAME_BITS = 11;
    // Start, parity and stop surround the payload.
    localparam int DATA_BITS  = FRAME_BITS - 3;

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return (^data) ^ parity;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered pointers and an occupancy count;
// the head word reads as zero while empty.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  n_res,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [DEPTH_LOG2:0]   count_r;
    logic                  do_push_s;
    logic                  do_pop_s;

    // Status, qualified push/pop and the zero-forced head read.
    always_comb begin
        empty     = (count_r == (DEPTH_LOG2+1)'(0));
        full      = (count_r == (DEPTH_LOG2+1)'(DEPTH));
        do_pop_s  = pop & ~empty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        do_push_s = push & (~full | do_pop_s);
        if (empty) begin
            rdata = {WIDTH{1'b0}};
        end else begin
            rdata = mem_r[rd_ptr_r];
        end
        count = count_r;
    end

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (!n_res) begin
            wr_ptr_r <= {DEPTH_LOG2{1'b0}};
            rd_ptr_r <= {DEPTH_LOG2{1'b0}};
            count_r  <= {(DEPTH_LOG2+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + DEPTH_LOG2'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + DEPTH_LOG2'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (DEPTH_LOG2+1)'(1);
                2'b01:   count_r <= count_r - (DEPTH_LOG2+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ps2_scan_fifo.sv
// PS/2 keyboard receive front end: synchronises the pins, deframes 11-bit
// device-to-host frames and queues good scan codes for the CPU.
module ps2_scan_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH_LOG2    = 3,
    parameter int TIMEOUT_TICKS = 2,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       n_res,
    input  logic       ps2_clock,
    input  logic       ps2_data,
    input  logic       tim_tick,
    input  logic       rd_pop,
    input  logic       clr_err,
    output logic [7:0] rd_data,
    output logic       irq,
    output logic       fifo_full,
    output logic       overflow,
    output logic       frame_err
);

    localparam int TMO_W = $clog2(TIMEOUT_TICKS + 1);

    logic [SYNC_STAGES-1:0] clk_sync_r;
    logic [SYNC_STAGES-1:0] data_sync_r;
    logic                   clk_prev_r;
    logic                   clk_s;
    logic                   data_s;
    logic                   fall_s;

    ps2_state_e             state_r;
    ps2_state_e             state_nxt_s;
    logic [2:0]             bit_cnt_r;
    logic [2:0]             bit_cnt_nxt_s;
    logic [7:0]             shift_r;
    logic [7:0]             shift_nxt_s;
    logic                   parity_r;
    logic                   parity_nxt_s;
    logic [TMO_W-1:0]       tmo_cnt_r;
    logic [TMO_W-1:0]       tmo_cnt_nxt_s;
    logic                   push_s;
    logic                   frame_bad_s;
    logic                   drop_s;

    logic                   overflow_r;
    logic                   frame_err_r;
    logic [7:0]             fifo_rdata_s;
    logic [DEPTH_LOG2:0]    fifo_count_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;

    // Pin synchronisers and the previous synchronised clock for edge detect.
    always_ff @(posedge clk) begin
        if (!n_res) begin
            clk_sync_r  <= {SYNC_STAGES{1'b1}};
            data_sync_r <= {SYNC_STAGES{1'b1}};
            clk_prev_r  <= 1'b1;
        end else begin
            clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], ps2_clock};
            data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], ps2_data};
            clk_prev_r  <= clk_s;
        end
    end

    assign clk_s  = clk_sync_r[SYNC_STAGES-1];
    assign data_s = data_sync_r[SYNC_STAGES-1];
    assign fall_s = clk_prev_r & ~clk_s;

    // Deframer state and datapath registers.
    always_ff @(posedge clk) begin
        if (!n_res) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
            parity_r  <= 1'b0;
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
            shift_r   <= shift_nxt_s;
            parity_r  <= parity_nxt_s;
            tmo_cnt_r <= tmo_cnt_nxt_s;
        end
    end

    // Next-state logic: frame walk on each fall, then the inactivity abort.
    always_comb begin
        state_nxt_s   = state_r;
        bit_cnt_nxt_s = bit_cnt_r;
        shift_nxt_s   = shift_r;
        parity_nxt_s  = parity_r;
        tmo_cnt_nxt_s = tmo_cnt_r;
        push_s        = 1'b0;
        frame_bad_s   = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // A fall with data high is line noise, not a start bit.
                if (fall_s && !data_s) begin
                    state_nxt_s   = ST_DATA;
                    bit_cnt_nxt_s = 3'd0;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (fall_s) begin
                    shift_nxt_s   = {data_s, shift_r[7:1]};
                    bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'(DATA_BITS - 1)) begin
                        state_nxt_s = ST_PARITY;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (fall_s) begin
                    parity_nxt_s = data_s;
                    state_nxt_s  = ST_STOP;
                end else begin
                    state_nxt_s  = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (fall_s) begin
                    state_nxt_s = ST_IDLE;
                    if (odd_parity_ok(shift_r, parity_r) && data_s) begin
                        push_s = 1'b1;
                    end else begin
                        frame_bad_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        // Edge activity restarts the timeout; ticks only count while silent.
        if (state_r == ST_IDLE) begin
            tmo_cnt_nxt_s = {TMO_W{1'b0}};
        end else if (fall_s) begin
            tmo_cnt_nxt_s = {TMO_W{1'b0}};
        end else if (tim_tick) begin
            if (tmo_cnt_r + TMO_W'(1) == TMO_W'(TIMEOUT_TICKS)) begin
                state_nxt_s   = ST_IDLE;
                tmo_cnt_nxt_s = {TMO_W{1'b0}};
                frame_bad_s   = 1'b1;
            end else begin
                tmo_cnt_nxt_s = tmo_cnt_r + TMO_W'(1);
            end
        end else begin
            tmo_cnt_nxt_s = tmo_cnt_r;
        end
    end

    // A byte is lost only when full and no pop frees a slot this cycle.
    assign drop_s = push_s & fifo_full_s & ~(rd_pop & ~fifo_empty_s);

    // Sticky error flags; a new error outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!n_res) begin
            overflow_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (clr_err) begin
                overflow_r <= 1'b0;
            end
            if (frame_bad_s) begin
                frame_err_r <= 1'b1;
            end else if (clr_err) begin
                frame_err_r <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .n_res (n_res),
        .push  (push_s),
        .pop   (rd_pop),
        .wdata (shift_r),
        .rdata (fifo_rdata_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign rd_data   = fifo_rdata_s;
    assign irq       = (fifo_count_s != (DEPTH_LOG2+1)'(0));
    assign fifo_full = fifo_full_s;
    assign overflow  = overflow_r;
    assign frame_err = frame_err_r;

endmodule

// File: tb/tb_ps2_scan_fifo.sv
// Directed bench for ps2_scan_fifo: a queue-based model of the received byte
// stream is compared with the DUT outputs every cycle, plus literal spot checks.
module tb_ps2_scan_fifo;

    // PS/2 half period in CPU clocks, scaled down so the run stays short.
    localparam int HALF = 20;

    logic       CPUCLK = 1'b0;
    logic       n_res = 1'b0;
    logic       ps2_clock = 1'b1;
    logic       ps2_data = 1'b1;
    logic       tick_bg = 1'b0;
    logic       tick_man = 1'b0;
    logic       tim_tick;
    logic       rd_pop = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] rd_data;
    logic       irq;
    logic       fifo_full;
    logic       overflow;
    logic       frame_err;

    logic [7:0] mq[$];
    logic       m_ovf = 1'b0;
    logic       m_ferr = 1'b0;
    logic       model_valid = 1'b0;
    logic       tick_en = 1'b0;
    logic [7:0] c_exp_rd;
    int         n_checks = 0;
    int         n_fail = 0;

    assign tim_tick = tick_bg | tick_man;

    ps2_scan_fifo dut (
        .clk       (CPUCLK),
        .n_res     (n_res),
        .ps2_clock (ps2_clock),
        .ps2_data  (ps2_data),
        .tim_tick  (tim_tick),
        .rd_pop    (rd_pop),
        .clr_err   (clr_err),
        .rd_data   (rd_data),
        .irq       (irq),
        .fifo_full (fifo_full),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    always #5 CPUCLK = ~CPUCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge CPUCLK);
        #1;
    endtask

    task automatic model_push(input logic [7:0] d);
        if (mq.size() == 8) begin
            m_ovf = 1'b1;
        end else begin
            mq.push_back(d);
        end
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_cycles(HALF / 2);
        ps2_clock = 1'b0;
        wait_cycles(HALF);
        ps2_clock = 1'b1;
        wait_cycles(HALF / 2);
    endtask

    // Full frame; bad_par flips parity, pop_at_stop lands a pop on the push cycle.
    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic pop_at_stop);
        logic par;
        par = ~(^d) ^ bad_par;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i]);
        end
        send_bit(par);
        ps2_data = 1'b1;
        wait_cycles(HALF / 2);
        model_valid = 1'b0;
        ps2_clock = 1'b0;
        if (pop_at_stop) begin
            // The stop-bit fall is acted on at the third clock edge after the pin moves.
            @(posedge CPUCLK);
            @(posedge CPUCLK);
            #1 rd_pop = 1'b1;
            @(posedge CPUCLK);
            #1 rd_pop = 1'b0;
        end else begin
            wait_cycles(3);
        end
        wait_cycles(4);
        if (pop_at_stop && mq.size() != 0) begin
            void'(mq.pop_front());
        end
        if (bad_par) begin
            m_ferr = 1'b1;
        end else begin
            model_push(d);
        end
        model_valid = 1'b1;
        wait_cycles(HALF - 7);
        ps2_clock = 1'b1;
        wait_cycles(HALF / 2);
    endtask

    task automatic pop_expect(input string name, input logic [7:0] exp);
        check(name, rd_data, exp);
        rd_pop = 1'b1;
        @(posedge CPUCLK);
        #1 rd_pop = 1'b0;
        if (mq.size() != 0) begin
            void'(mq.pop_front());
        end
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(posedge CPUCLK);
        #1 clr_err = 1'b0;
        m_ovf  = 1'b0;
        m_ferr = 1'b0;
    endtask

    task automatic pulse_tick();
        tick_man = 1'b1;
        @(posedge CPUCLK);
        #1 tick_man = 1'b0;
    endtask

    // Background timebase, slow enough that a live frame never times out.
    initial begin
        forever begin
            repeat (97) @(posedge CPUCLK);
            if (tick_en) begin
                #1 tick_bg = 1'b1;
                @(posedge CPUCLK);
                #1 tick_bg = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model on the falling clock edge.
    always @(negedge CPUCLK) begin
        if (model_valid) begin
            c_exp_rd = (mq.size() != 0) ? mq[0] : 8'h00;
            check("rd_data", rd_data, c_exp_rd);
            check("irq", irq, (mq.size() != 0) ? 1'b1 : 1'b0);
            check("fifo_full", fifo_full, (mq.size() == 8) ? 1'b1 : 1'b0);
            check("overflow", overflow, m_ovf);
            check("frame_err", frame_err, m_ferr);
        end
    end

    initial begin
        n_res = 1'b0;
        wait_cycles(3);
        model_valid = 1'b1;
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_irq", irq, 1'b0);
        check("rst_full", fifo_full, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        n_res = 1'b1;
        tick_en = 1'b1;
        wait_cycles(5);

        // Single frame, then pop.
        send_frame(8'h1C, 1'b0, 1'b0);
        check("t1_irq", irq, 1'b1);
        check("t1_data", rd_data, 8'h1C);
        pop_expect("t1_pop", 8'h1C);
        check("t1_irq_clr", irq, 1'b0);
        check("t1_data_clr", rd_data, 8'h00);

        // Back-to-back burst keeps order.
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        pop_expect("t2_pop0", 8'hE0);
        pop_expect("t2_pop1", 8'hF0);
        check("t2_irq_mid", irq, 1'b1);
        pop_expect("t2_pop2", 8'h1C);
        check("t2_irq_end", irq, 1'b0);

        // Fill, overflow on the ninth byte.
        for (int i = 1; i <= 8; i++) begin
            send_frame(8'(i), 1'b0, 1'b0);
        end
        check("t3_full", fifo_full, 1'b1);
        check("t3_ovf0", overflow, 1'b0);
        send_frame(8'h09, 1'b0, 1'b0);
        check("t3_ovf1", overflow, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            pop_expect("t3_pop", 8'(i));
        end
        check("t3_empty", irq, 1'b0);
        pop_expect("t3_pop9", 8'h00);
        check("t3_empty9", irq, 1'b0);
        check("t3_ovf_keep", overflow, 1'b1);
        pulse_clr();
        check("t3_ovf_clr", overflow, 1'b0);

        // Same fill with a pop coincident with the ninth push.
        for (int i = 1; i <= 8; i++) begin
            send_frame(8'(i), 1'b0, 1'b0);
        end
        send_frame(8'h09, 1'b0, 1'b1);
        check("t3b_ovf", overflow, 1'b0);
        check("t3b_full", fifo_full, 1'b1);
        for (int i = 2; i <= 9; i++) begin
            pop_expect("t3b_pop", 8'(i));
        end
        check("t3b_empty", irq, 1'b0);

        // Parity error, clear, then a good frame.
        send_frame(8'h1C, 1'b1, 1'b0);
        check("t4_irq", irq, 1'b0);
        check("t4_ferr", frame_err, 1'b1);
        pulse_clr();
        check("t4_ferr_clr", frame_err, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b0);
        pop_expect("t4_pop", 8'h5A);

        // Timeout abort after a partial frame.
        tick_en = 1'b0;
        wait_cycles(3);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        wait_cycles(10);
        pulse_tick();
        wait_cycles(5);
        check("t5_ferr_one_tick", frame_err, 1'b0);
        model_valid = 1'b0;
        pulse_tick();
        wait_cycles(2);
        m_ferr = 1'b1;
        model_valid = 1'b1;
        check("t5_ferr", frame_err, 1'b1);
        tick_en = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b0);
        check("t5_irq", irq, 1'b1);
        pop_expect("t5_pop", 8'h5A);
        check("t5_ferr_keep", frame_err, 1'b1);
        pulse_clr();

        // Reset mid-frame, then a clean frame.
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) begin
            send_bit(i[0]);
        end
        model_valid = 1'b0;
        n_res = 1'b0;
        @(posedge CPUCLK);
        #1 n_res = 1'b1;
        mq.delete();
        m_ovf  = 1'b0;
        m_ferr = 1'b0;
        model_valid = 1'b1;
        wait_cycles(4);
        send_frame(8'h29, 1'b0, 1'b0);
        check("t6_data", rd_data, 8'h29);
        check("t6_ovf", overflow, 1'b0);
        check("t6_ferr", frame_err, 1'b0);
        pop_expect("t6_pop", 8'h29);
        check("t6_empty", irq, 1'b0);

        wait_cycles(5);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_scan_fifo.md
Name: ps2_scan_fifo

Overview:
- Front end for the PS/2 keyboard port. Oversamples raw PS/2 clock/data pins on the CPU clock and deframes 11-bit device-to-host frames.
- Checks start/parity/stop, pushes good scan codes into a small FIFO, and presents the head byte plus a level IRQ to the I/O glue.
- The glue decodes port 0xE8 reads into `rd_pop`, drives `rd_data` onto D, and turns `irq` into nINT.
- Replaces the single-byte latch so bursts (break codes, E0 prefixes) are not lost while the CPU is slow.

Parameters:
- DEPTH_LOG2, 3, FIFO depth = 2^DEPTH_LOG2 entries (8).
- TIMEOUT_TICKS, 2, `tim_tick` pulses without a PS/2 falling edge that abort a partial frame.
- SYNC_STAGES, 2, synchroniser flops on `ps2_clock` and `ps2_data` (minimum 2).

Ports:
- clk  in  1  CPU clock; all state changes on its rising edge.
- n_res  in  1  reset, synchronous, active-low.
- ps2_clock  in  1  raw PS/2 clock pin (asynchronous).
- ps2_data  in  1  raw PS/2 data pin (asynchronous).
- tim_tick  in  1  single-cycle timebase strobe, period ≥ 200 µs.
- rd_pop  in  1  single-cycle pop request (one per CPU read of the data port).
- clr_err  in  1  single-cycle clear of the sticky error flags.
- rd_data  out  8  FIFO head byte; 0x00 when empty.
- irq  out  1  high while FIFO is non-empty.
- fifo_full  out  1  count == 2^DEPTH_LOG2.
- overflow  out  1  sticky: a good byte was dropped because the FIFO was full.
- frame_err  out  1  sticky: parity error, stop=0, or timeout abort.

Behaviour:
- Reset (`n_res`=0 at a clk edge):
  - Synchronisers load 1; FSM goes to IDLE; bit counter and timeout counter go to 0.
  - FIFO pointers and count go to 0.
  - Outputs: `rd_data`=0x00, `irq`=0, `fifo_full`=0, `overflow`=0, `frame_err`=0.
  - Reset mid-frame discards the partial frame with no flag set.
- Edge detect:
  - `fall` = previous synchronised clock 1 AND current synchronised clock 0.
  - Data is the synchronised `ps2_data` sampled in the same cycle `fall` is seen.
  - Pin-to-`fall` latency is SYNC_STAGES+1 cycles.
- FSM:
  - IDLE: on `fall`, data=0 goes to DATA (bit counter = 0); data=1 is a spurious edge and the FSM stays in IDLE.
  - DATA: on `fall`, shift data into shift[7] (LSB first, right-shift). After the 8th bit go to PARITY.
  - PARITY: on `fall`, store the bit and go to STOP.
  - STOP: on `fall`, check the frame. Odd parity means (XOR of the 8 data bits) XOR parity = 1.
    - Parity good and stop bit = 1: push the byte.
    - Otherwise: set `frame_err` and do not push.
    - Either way, return to IDLE.
- Timeout:
  - In any state other than IDLE, count `tim_tick`. The counter clears on every `fall`.
  - When the count reaches TIMEOUT_TICKS: go to IDLE and set `frame_err`.
  - If `fall` and `tim_tick` occur in the same cycle, the edge wins.
- Push timing:
  - The push happens at the clk edge ending the STOP-`fall` cycle E.
  - From cycle E+1: `irq`=1 and `rd_data` shows the byte if the FIFO was previously empty.
- FIFO:
  - Registered pointers with DEPTH_LOG2+1-bit count; pointers wrap modulo depth.
  - `rd_data` is a combinational read at the read pointer, forced to 0x00 when count=0.
  - `rd_pop` when empty is ignored (no pointer move, no flag).
  - Push when full: byte dropped, `overflow` set, contents unchanged.
  - Push and pop in the same cycle:
    - Not empty: both happen, count unchanged (this includes the full case, so nothing is dropped).
    - Empty: push only.
- Sticky flags: `clr_err` clears both `overflow` and `frame_err`. A set event in the same cycle wins over the clear.
- Outputs:
  - `irq` = (count≠0), derived from registered count.
  - `fifo_full` = (count==depth).

Decomposition:
- Shared package `ps2_pkg` holds:
  - FSM state enum (IDLE, DATA, PARITY, STOP);
  - the frame-length constant 11;
  - the parity function.
- One sub-module, `sync_fifo` (generic width 8, parameter DEPTH_LOG2). Its ports are push, pop, wdata, rdata, count, full, empty.
- Synchroniser, edge detect, FSM and flags stay in `ps2_scan_fifo`.

Test Plan:
- Frame 0x1C (start 0, data LSB-first 0,0,1,1,1,0,0,0, parity 0, stop 1; 40 µs half-periods) → `irq` rises; `rd_data`=0x1C. `rd_pop` → `irq`=0, `rd_data`=0x00.
- Frames 0xE0, 0xF0, 0x1C back-to-back with no pops → reads return 0xE0, 0xF0, 0x1C in order; `irq` drops after the third pop.
- Nine frames 0x01–0x09 with no pops:
  - after 0x08, `fifo_full`=1;
  - 0x09 sets `overflow` and is dropped;
  - pops yield 0x01–0x08 and a 9th pop leaves count 0.
  - Repeat with a `rd_pop` coincident with the 9th push → 0x09 accepted, `overflow` stays 0.
- Frame 0x1C with parity 1 → no push, `irq`=0, `frame_err`=1. `clr_err` → 0. A following good 0x5A frame is received normally.
- Four bits then clock held high for 2 `tim_tick` → FSM in IDLE, `frame_err`=1. A following 0x5A frame is received correctly.
- `n_res` low for one cycle after the 5th data bit, then a full 0x29 frame → only 0x29 in the FIFO, both error flags 0.
